// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data has fixed priority; a saturating starvation counter hands fetch a contested slot.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                own_data_q, own_data_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic                i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                pick_data, pick_fetch;

  // Fetch only overrides data once it has lost STARVE_LIMIT contested rounds.
  assign pick_data  = d_req && !(i_req && (starve_q == CNT_MAX));
  assign pick_fetch = i_req && !pick_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      own_data_q <= 1'b0;
      starve_q   <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      starve_q   <= starve_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req || d_req) state_d = S_MEM;
      S_MEM:   if (m_ack)          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    own_data_d = own_data_q;
    starve_d   = starve_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    if (state_q == S_IDLE) begin
      if (pick_data) begin
        d_gnt_d    = 1'b1;
        own_data_d = 1'b1;
        m_req_d    = 1'b1;
        m_we_d     = d_we;
        m_addr_d   = d_addr;
        m_wdata_d  = d_wdata;
        m_wstrb_d  = d_wstrb;
        if (i_req && (starve_q < CNT_MAX)) starve_d = starve_q + CNT_W'(1);
      end else if (pick_fetch) begin
        i_gnt_d    = 1'b1;
        own_data_d = 1'b0;
        m_req_d    = 1'b1;
        m_we_d     = 1'b0;
        m_addr_d   = i_addr;
        m_wdata_d  = '0;
        m_wstrb_d  = '0;
        starve_d   = '0;
      end
    end else if (m_ack) begin
      m_req_d = 1'b0;
      if (own_data_q) begin
        d_rvalid_d = 1'b1;
        if (!m_we_q) d_rdata_d = m_rdata;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = m_rdata;
      end
    end
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign busy     = (state_q == S_MEM);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the core's single unified memory between the instruction-fetch path and the load/store path. It sits between the core's fetch and data units and the byte-addressed memory. Each request gets exactly one memory transaction under a request/grant/response handshake. Data accesses have fixed priority, and a saturating starvation counter bounds how long instruction fetch can be held off.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- STARVE_LIMIT, 4, consecutive fetch losses after which fetch wins a contested arbitration (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request accepted
- i_rvalid  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched word, held until next fetch completion
- d_req  in  1  data request; held with d_* fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load or store complete
- d_rdata  out  DATA_W  load data, held; not updated by stores
- m_req  out  1  memory request, held until m_ack sampled
- m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields
- m_ack  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DATA_W  memory read data
- busy  out  1  high while state is MEM

## Operation
- Two-state FSM: IDLE and MEM. All outputs are registered.
- IDLE, neither request: stay in IDLE and drive no outputs.
- IDLE, exactly one request: grant it.
- IDLE, both requests: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- On a grant:
  - Pulse the owner's gnt.
  - Latch owner and fields into m_*. Fetch forces m_we=0, m_wstrb=0, m_wdata=0.
  - Set m_req=1 and go to MEM.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Incremented, saturating at STARVE_LIMIT, on a contested grant to data.
  - Cleared on any fetch grant.
  - Unchanged by uncontested data grants.
- MEM, m_ack=0: hold every m_* field stable.
- MEM, m_ack=1:
  - Set m_req=0.
  - Pulse the owner's rvalid.
  - Capture m_rdata into the owner's rdata; data stores leave d_rdata unchanged.
  - Return to IDLE.
- m_ack while in IDLE is ignored. Requests arriving while in MEM wait and are not queued or dropped.
- Asynchronous reset, at any time including mid-transaction:
  - State=IDLE, starve_cnt=0.
  - All outputs 0, including the rdata registers.
  - The in-flight transaction is abandoned and never produces rvalid.

## Timing
- Edge k, IDLE, req sampled: from k, gnt=1, m_req=1, busy=1.
- Edge k+1: gnt=0. The requester may change req/fields from k+1.
- Edge n, m_ack sampled: from n, m_req=0, busy=0, rvalid=1 with rdata valid.
- Edge n+1: rvalid=0; a pending request can be granted at this edge.
- Latency from gnt to rvalid is (n−k) cycles, minimum 1 (m_ack at k+1).
- Minimum issue interval is 2 cycles per transaction.
- Both gnt, and both rvalid, are never high simultaneously.

## Test plan
- Single fetch: i_req, i_addr=0x24; m_ack 2 cycles after m_req with m_rdata=0x00500293.
  - Required: i_gnt one cycle; m_addr=0x24, m_we=0.
  - Required: i_rvalid for one cycle, the cycle after m_ack, with i_rdata=0x00500293; d_* outputs stay 0.
- Contested request: i_req and d_req rise together, d_we=0, d_addr=0x100.
  - Required: d_gnt first, then i_gnt at the edge after d's m_ack.
- Starvation, STARVE_LIMIT=4: d_req and i_req held continuously, m_ack=1 immediately.
  - Required grant order: D, D, D, D, I, D, D, D, D, I.
- Store: d_we=1, d_addr=0x28, d_wdata=0xDEADBEEF, d_wstrb=4'b0011.
  - Required: m_we=1, m_wstrb=0011, m_wdata=0xDEADBEEF, all held until m_ack.
  - Required: d_rvalid pulses once; d_rdata keeps its prior load value.
- Reset mid-MEM: assert reset between clock edges while m_req=1.
  - Required: m_req/busy drop at once without waiting for a clock edge.
  - Required: a late m_ack after deassertion produces no rvalid; starve_cnt=0.
- Stray m_ack: pulse m_ack in IDLE with no requests.
  - Required: no rvalid, rdata unchanged, state stays IDLE.
